// File: rtl/adder_pkg.sv
// adder_pkg
//   Shared definitions for the chunked serial adder:
//     state_t  - controller states (idle / running chunks / result ready)
//     cnt_w()  - width of the chunk counter for a given chunk count
//                (clog2 of the count, never less than one bit)
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// chunk_ripple_adder
//   Purely combinational CHUNK-bit ripple-carry slice.
//   Ports:
//     a, b   in  CHUNK  slice operands
//     ci     in  1      carry into bit 0
//     s      out CHUNK  slice sum
//     co     out 1      carry out of the MSB
//     c_msb  out 1      carry into the MSB (used for signed overflow)
module chunk_ripple_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    // c[i] is the carry into bit i
    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder
//   Multi-cycle WIDTH-bit adder that pushes CHUNK bits per clock through one
//   shared ripple-carry slice, holding the carry in a register between chunks.
//   Latency is NCHUNK = WIDTH/CHUNK cycles of RUN followed by a one-cycle DONE.
//
//   Optional feature macro: ADDER_SUB_EN
//     defined   - sub selects a - b - cin, computed as a + ~b + ~cin
//     undefined - sub is ignored, result is always a + b + cin
//
//   Ports:
//     clk    in   rising-edge clock
//     rst    in   synchronous active-high reset
//     start  in   request a new operation (accepted in IDLE or DONE)
//     a, b   in   WIDTH-bit operands, captured on accepted start
//     cin    in   carry-in (borrow-in when subtracting), captured on start
//     sub    in   subtract select, captured on start
//     busy   out  high while chunks are being processed
//     done   out  single-cycle completion pulse
//     sum    out  registered result
//     cout   out  carry out of bit WIDTH-1 (inverted borrow when subtracting)
//     ovf    out  two's-complement signed overflow
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int CHUNK  = 4,
    parameter int NCHUNK = WIDTH / CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int KW = cnt_w(NCHUNK);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
    end

    logic eff_sub;
`ifdef ADDER_SUB_EN
    assign eff_sub = sub;
`else
    // Subtract is compiled out; sub is deliberately left dangling.
    logic sub_unused;
    assign sub_unused = sub;
    assign eff_sub    = 1'b0;
`endif

    state_t           state, state_nxt;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_r, b_r, work;
    logic             carry;

    logic [CHUNK-1:0] s_chunk;
    logic             co_chunk, cmsb_chunk;
    logic [WIDTH-1:0] work_nxt;
    logic             last, accept;

    // Operands are shifted right each RUN cycle so the slice always sees
    // bits [CHUNK-1:0]; the result enters from the top of the working
    // register, so after NCHUNK cycles it is fully aligned.
    chunk_ripple_adder #(.CHUNK(CHUNK)) u_slice (
        .a     (a_r[CHUNK-1:0]),
        .b     (b_r[CHUNK-1:0]),
        .ci    (carry),
        .s     (s_chunk),
        .co    (co_chunk),
        .c_msb (cmsb_chunk)
    );

    assign work_nxt = (work >> CHUNK) | (WIDTH'(s_chunk) << (WIDTH - CHUNK));
    assign last     = (k == KW'(NCHUNK - 1));
    assign accept   = start && (state != ST_RUN);
    assign busy     = (state == ST_RUN);
    assign done     = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            k     <= '0;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            work  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_r   <= a;
                b_r   <= eff_sub ? ~b : b;
                carry <= cin ^ eff_sub;
                k     <= '0;
            end else if (state == ST_RUN) begin
                a_r   <= a_r >> CHUNK;
                b_r   <= b_r >> CHUNK;
                carry <= co_chunk;
                work  <= work_nxt;
                k     <= k + KW'(1);
                // Results only change on entry to DONE, so they hold the
                // previous answer through any following RUN.
                if (last) begin
                    sum  <= work_nxt;
                    cout <= co_chunk;
                    ovf  <= cmsb_chunk ^ co_chunk;
                end
            end
        end
    end

endmodule
